// File: rtl/mem_arbiter.sv
// Arbitrates the shared backing-memory port between icache and dcache misses.
// Round-robin on ties; sequences request, response and read timeout.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_resp_valid,
    output logic [DATA_W-1:0] ic_resp_data,
    input  logic              dc_req_valid,
    input  logic              dc_req_rw,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [DATA_W-1:0] dc_req_wdata,
    output logic              dc_req_ready,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] dc_resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              stall,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic SEL_IC = 1'b0;
    localparam logic SEL_DC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              last_grant_reg, last_grant_next;
    logic              rw_reg, rw_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              err_reg, err_next;
    logic              ic_resp_valid_reg, ic_resp_valid_next;
    logic              dc_resp_valid_reg, dc_resp_valid_next;
    logic [DATA_W-1:0] ic_resp_data_reg, ic_resp_data_next;
    logic [DATA_W-1:0] dc_resp_data_reg, dc_resp_data_next;

    logic              grant_ic;
    logic              grant_dc;
    logic [DATA_W-1:0] wait_data;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (ic_req_valid && dc_req_valid) begin
                grant_dc = (last_grant_reg == SEL_IC);
                grant_ic = (last_grant_reg == SEL_DC);
            end else begin
                grant_ic = ic_req_valid;
                grant_dc = dc_req_valid;
            end
        end
    end

    // A timed-out read returns an all-zero line.
    assign wait_data = mem_resp_valid ? mem_resp_data : '0;

    always_comb begin
        state_next         = state_reg;
        owner_next         = owner_reg;
        last_grant_next    = last_grant_reg;
        rw_next            = rw_reg;
        addr_next          = addr_reg;
        wdata_next         = wdata_reg;
        cnt_next           = cnt_reg;
        err_next           = err_reg;
        ic_resp_valid_next = 1'b0;
        dc_resp_valid_next = 1'b0;
        ic_resp_data_next  = ic_resp_data_reg;
        dc_resp_data_next  = dc_resp_data_reg;

        case (state_reg)
            ST_IDLE: begin
                if (grant_ic || grant_dc) begin
                    owner_next      = grant_dc ? SEL_DC : SEL_IC;
                    last_grant_next = grant_dc ? SEL_DC : SEL_IC;
                    rw_next         = grant_dc & dc_req_rw;
                    addr_next       = grant_dc ? dc_req_addr : ic_req_addr;
                    wdata_next      = grant_dc ? dc_req_wdata : '0;
                    state_next      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    if (rw_reg) begin
                        dc_resp_valid_next = 1'b1;
                        dc_resp_data_next  = '0;
                        state_next         = ST_IDLE;
                    end else begin
                        cnt_next   = '0;
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid || (cnt_reg == CNT_LAST)) begin
                    if (!mem_resp_valid) begin
                        err_next = 1'b1;
                    end
                    if (owner_reg == SEL_DC) begin
                        dc_resp_valid_next = 1'b1;
                        dc_resp_data_next  = wait_data;
                    end else begin
                        ic_resp_valid_next = 1'b1;
                        ic_resp_data_next  = wait_data;
                    end
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= ST_IDLE;
            owner_reg         <= SEL_IC;
            last_grant_reg    <= SEL_IC;
            rw_reg            <= 1'b0;
            addr_reg          <= '0;
            wdata_reg         <= '0;
            cnt_reg           <= '0;
            err_reg           <= 1'b0;
            ic_resp_valid_reg <= 1'b0;
            dc_resp_valid_reg <= 1'b0;
            ic_resp_data_reg  <= '0;
            dc_resp_data_reg  <= '0;
        end else begin
            state_reg         <= state_next;
            owner_reg         <= owner_next;
            last_grant_reg    <= last_grant_next;
            rw_reg            <= rw_next;
            addr_reg          <= addr_next;
            wdata_reg         <= wdata_next;
            cnt_reg           <= cnt_next;
            err_reg           <= err_next;
            ic_resp_valid_reg <= ic_resp_valid_next;
            dc_resp_valid_reg <= dc_resp_valid_next;
            ic_resp_data_reg  <= ic_resp_data_next;
            dc_resp_data_reg  <= dc_resp_data_next;
        end
    end

    assign ic_req_ready  = grant_ic;
    assign dc_req_ready  = grant_dc;
    assign ic_resp_valid = ic_resp_valid_reg;
    assign ic_resp_data  = ic_resp_data_reg;
    assign dc_resp_valid = dc_resp_valid_reg;
    assign dc_resp_data  = dc_resp_data_reg;
    assign mem_req_valid = (state_reg == ST_REQ);
    assign mem_req_rw    = rw_reg;
    assign mem_req_addr  = addr_reg;
    assign mem_req_wdata = wdata_reg;
    assign err           = err_reg;
    assign stall         = (state_reg != ST_IDLE) | ic_req_valid | dc_req_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level model predicts
// grant order and response contents; a monitor compares every ready and resp pulse.
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 128;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ic_req_valid, ic_req_ready, ic_resp_valid;
    logic [ADDR_W-1:0] ic_req_addr;
    logic [DATA_W-1:0] ic_resp_data;
    logic              dc_req_valid, dc_req_rw, dc_req_ready, dc_resp_valid;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [DATA_W-1:0] dc_req_wdata, dc_resp_data;
    logic              mem_req_valid, mem_req_ready, mem_req_rw, mem_resp_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata, mem_resp_data;
    logic              stall, err;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              owner;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    typedef struct {
        logic              owner;
        logic [DATA_W-1:0] data;
        logic              err;
    } resp_t;

    logic  grant_q[$];
    txn_t  txn_q[$];
    resp_t exp_q[$];

    int   checks_total  = 0;
    int   checks_passed = 0;
    int   resp_seen     = 0;
    int   resp_expected = 0;
    bit   resp_en       = 1'b0;
    int   force_k       = -1;
    int   force_rw      = -1;
    logic model_last    = 1'b0;
    logic model_err     = 1'b0;

    logic  mon_g;
    resp_t mon_e;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DATA_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: one line per transaction (grant or response).
    always @(negedge clk) begin
        if (reset) begin
            if (ic_req_ready || dc_req_ready) begin
                check("ready_onehot", ic_req_ready & dc_req_ready, 0);
                check("grant_expected", grant_q.size() > 0, 1);
                if (grant_q.size() > 0) begin
                    mon_g = grant_q.pop_front();
                    $display("grant %s at %0t", dc_req_ready ? "DC" : "IC", $time);
                    check("grant_owner", dc_req_ready, mon_g);
                end
            end
            if (ic_resp_valid || dc_resp_valid) begin
                resp_seen++;
                check("resp_onehot", ic_resp_valid & dc_resp_valid, 0);
                check("resp_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    $display("resp %s data=0x%0h err=%0b at %0t", dc_resp_valid ? "DC" : "IC",
                             dc_resp_valid ? dc_resp_data : ic_resp_data, err, $time);
                    check("resp_owner", dc_resp_valid, mon_e.owner);
                    check("resp_data", dc_resp_valid ? dc_resp_data : ic_resp_data, mon_e.data);
                    check("resp_err", err, mon_e.err);
                end
            end
        end
    end

    // Memory model: random accept delay, random response latency incl. timeouts.
    initial begin : responder
        txn_t  t;
        resp_t r;
        int    dly;
        int    k;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (resp_en && reset && mem_req_valid) begin
                check("mem_req_expected", txn_q.size() > 0, 1);
                if (txn_q.size() > 0) begin
                    t   = txn_q.pop_front();
                    dly = int'($urandom_range(0, 2));
                    for (int i = 0; i <= dly; i++) begin
                        check("mem_req_valid", mem_req_valid, 1);
                        check("mem_req_rw", mem_req_rw, t.rw);
                        check("mem_req_addr", mem_req_addr, t.addr);
                        check("mem_req_wdata", mem_req_wdata, t.wdata);
                        if (i == dly) mem_req_ready = 1'b1;
                        @(posedge clk); #1;
                    end
                    mem_req_ready = 1'b0;
                    check("mem_req_dropped", mem_req_valid, 0);
                    r.owner = t.owner;
                    if (t.rw) begin
                        r.data = '0;
                        r.err  = model_err;
                        exp_q.push_back(r);
                    end else begin
                        k = (force_k >= 0) ? force_k : int'($urandom_range(0, TIMEOUT + 1));
                        if (k < TIMEOUT) begin
                            r.data = rand_line();
                            r.err  = model_err;
                            exp_q.push_back(r);
                            repeat (k) begin @(posedge clk); #1; end
                            mem_resp_valid = 1'b1;
                            mem_resp_data  = r.data;
                            @(posedge clk); #1;
                            mem_resp_valid = 1'b0;
                            mem_resp_data  = rand_line();
                        end else begin
                            model_err = 1'b1;
                            r.data    = '0;
                            r.err     = 1'b1;
                            exp_q.push_back(r);
                            repeat (TIMEOUT) begin @(posedge clk); #1; end
                            if (k == TIMEOUT) begin
                                // late response after the abort must be ignored
                                mem_resp_valid = 1'b1;
                                mem_resp_data  = rand_line();
                                @(posedge clk); #1;
                                mem_resp_valid = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic push_txn(input txn_t t);
        grant_q.push_back(t.owner);
        txn_q.push_back(t);
        model_last = t.owner;
        resp_expected++;
    endtask

    // kind: 0 = icache only, 1 = dcache only, 2 = both at once
    task automatic do_round(input int kind, input logic [ADDR_W-1:0] ic_addr);
        txn_t ti;
        txn_t td;
        logic hs_ic;
        logic hs_dc;
        int   n;
        ti.owner = 1'b0; ti.rw = 1'b0; ti.addr = ic_addr; ti.wdata = '0;
        td.owner = 1'b1;
        td.rw    = (force_rw >= 0) ? force_rw[0] : 1'($urandom_range(0, 1));
        td.addr  = $urandom;
        td.wdata = rand_line();
        if (kind == 0) push_txn(ti);
        else if (kind == 1) push_txn(td);
        else if (model_last == 1'b0) begin push_txn(td); push_txn(ti); end
        else begin push_txn(ti); push_txn(td); end

        ic_req_valid = (kind != 1);
        ic_req_addr  = ti.addr;
        dc_req_valid = (kind != 0);
        dc_req_rw    = td.rw;
        dc_req_addr  = td.addr;
        dc_req_wdata = td.wdata;
        n = 0;
        while ((ic_req_valid || dc_req_valid) && n < 200) begin
            @(negedge clk);
            check("stall_with_req", stall, 1);
            hs_ic = ic_req_ready;
            hs_dc = dc_req_ready;
            @(posedge clk); #1;
            if (hs_ic) ic_req_valid = 1'b0;
            if (hs_dc) dc_req_valid = 1'b0;
            n++;
        end
        check("grant_in_time", n < 200, 1);
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        n = 0;
        while (resp_seen < resp_expected && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("resp_in_time", resp_seen >= resp_expected, 1);
        @(negedge clk);
        check("stall_idle", stall, 0);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : driver
        int snap;
        ic_req_valid = 1'b0; ic_req_addr = '0;
        dc_req_valid = 1'b0; dc_req_rw = 1'b0; dc_req_addr = '0; dc_req_wdata = '0;
        #1 reset = 1'b0;
        #3;
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_stall", stall, 0);
        check("rst_err", err, 0);
        check("rst_ic_resp_valid", ic_resp_valid, 0);
        check("rst_dc_resp_data", dc_resp_data, 0);
        check("rst_mem_req_addr", mem_req_addr, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        resp_en = 1'b1;

        // first tie after reset goes to DC; then alternating grants
        force_k = 3;
        do_round(2, 32'h2000);
        do_round(2, $urandom);
        force_k = TIMEOUT - 1;
        do_round(0, $urandom);
        check("err_after_collision", err, 0);
        force_k  = -1;
        force_rw = 1;
        do_round(1, $urandom);
        force_rw = -1;
        force_k  = TIMEOUT + 1;
        do_round(0, $urandom);
        check("err_after_timeout", err, 1);
        force_k = -1;
        for (int i = 0; i < 40; i++) begin
            do_round(int'($urandom_range(0, 2)), $urandom);
        end
        check("err_sticky", err, model_err);

        // asynchronous reset while a read waits for memory
        resp_en = 1'b0;
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h4000;
        grant_q.push_back(1'b0);
        @(posedge clk); #1;
        ic_req_valid = 1'b0;
        check("rst_test_req", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("async_mem_req_valid", mem_req_valid, 0);
        check("async_err", err, 0);
        check("async_stall", stall, 0);
        check("async_ic_resp_data", ic_resp_data, 0);
        check("async_mem_req_addr", mem_req_addr, 0);
        model_err  = 1'b0;
        model_last = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        snap = resp_seen;
        @(posedge clk); #1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = rand_line();
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_resp_after_reset", resp_seen, snap);
        resp_en = 1'b1;
        do_round(2, $urandom);
        check("err_after_reset", err, 0);

        check("grant_q_drained", grant_q.size(), 0);
        check("txn_q_drained", txn_q.size(), 0);
        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single backing-memory port between instruction-cache and data-cache miss traffic.
- Sits between the two caches and main memory.
- Grants one requester at a time with round-robin tie-break, and sequences request, response and timeout.
- Drives a stall signal that the pipeline ORs into its global stall.

Parameters:
ADDR_W, 32, request address width
DATA_W, 128, cache-line data width per transfer
TIMEOUT, 255, max cycles waiting for a read response before abort (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
ic_req_valid  input  1  icache read request pending
ic_req_addr  input  ADDR_W  icache line address
ic_req_ready  output  1  icache request accepted this cycle
ic_resp_valid  output  1  one-cycle pulse, ic_resp_data valid
ic_resp_data  output  DATA_W  line returned to icache
dc_req_valid  input  1  dcache request pending
dc_req_rw  input  1  1=write (writeback), 0=read
dc_req_addr  input  ADDR_W  dcache line address
dc_req_wdata  input  DATA_W  writeback data
dc_req_ready  output  1  dcache request accepted this cycle
dc_resp_valid  output  1  one-cycle pulse; read data or write ack
dc_resp_data  output  DATA_W  line returned to dcache (0 on write ack)
mem_req_valid  output  1  request to memory
mem_req_ready  input  1  memory accepts request
mem_req_rw  output  1  latched rw (icache always 0)
mem_req_addr  output  ADDR_W  latched address
mem_req_wdata  output  DATA_W  latched write data
mem_resp_valid  input  1  memory read data valid
mem_resp_data  input  DATA_W  memory read data
stall  output  1  pipeline must hold
err  output  1  sticky timeout flag

Behaviour:
- Reset (reset=0, immediate, async):
  - state=IDLE, last_grant=IC, owner=IC.
  - Latched addr/rw/wdata = 0; timeout counter = 0; err = 0.
  - All resp_valid = 0, resp_data = 0, mem_req_valid = 0.
- States: IDLE, REQ, WAIT.
- IDLE:
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the one != last_grant; first tie after reset goes to DC.
  - Winner's *_req_ready is combinationally 1 this cycle (the handshake); the other requester's ready is 0.
  - No valid request: stay in IDLE, both readies 0.
  - On grant, register addr/rw/wdata (icache rw forced 0), owner and last_grant; next state REQ.
- REQ:
  - mem_req_valid=1 with latched fields, held stable until mem_req_ready.
  - On mem_req_ready with rw=1: next state IDLE; next cycle dc_resp_valid=1, dc_resp_data=0 (write ack).
  - On mem_req_ready with rw=0: next state WAIT; counter cleared.
- WAIT:
  - mem_req_valid=0; counter increments every cycle.
  - On mem_resp_valid: next cycle owner's resp_valid=1 and resp_data=mem_resp_data (registered, 1-cycle latency); state IDLE.
  - If counter reaches TIMEOUT before mem_resp_valid: err sets (sticky until reset); owner gets resp_valid with data 0; state IDLE.
  - mem_resp_valid and timeout in the same cycle: the response wins, err unchanged.
- mem_resp_valid in IDLE or REQ is ignored.
- resp_valid outputs are single-cycle pulses; resp_data holds its last value until the next pulse.
- Requesters must hold valid and fields until ready; a requester may drop valid before grant without effect.
- A new grant may occur in the IDLE cycle directly after a response pulse: minimum occupancy 3 cycles per read, 2 per write.
- stall = (state != IDLE) | ic_req_valid | dc_req_valid, combinational.
- Reset asserted mid-transaction: outstanding transfer is abandoned, no resp pulse is produced; a later mem_resp_valid in IDLE is ignored.

Test Plan:
- Single icache read: ic_req_valid, addr 0x2000, mem_req_ready=1, mem_resp at 4th cycle with data 0xA5..A5 -> ic_req_ready in cycle 0, mem_req_addr=0x2000 rw=0, ic_resp_valid one cycle after resp with 0xA5..A5; dc_resp_valid stays 0.
- Simultaneous requests after reset: both valid, repeated 3 transactions -> grant order DC, IC, DC; stall high throughout.
- Dcache writeback: rw=1, addr 0x3040, wdata 0x1234, mem_req_ready delayed 2 cycles -> mem_req fields stable during wait, dc_resp_valid with data 0 the cycle after handshake, no WAIT state.
- Timeout: TIMEOUT=4, read, no mem_resp_valid -> after 4 WAIT cycles owner resp_valid=1, data 0, err=1 and sticky through subsequent good transactions.
- Async reset mid-WAIT: drop reset between edges -> outputs zero immediately; after release, late mem_resp_valid produces no resp pulse; next tie grants DC.
- Response/timeout collision: mem_resp_valid on the TIMEOUT cycle -> data delivered, err stays 0.
